// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-aligned reads to a fixed one-cycle-latency
// instruction memory and buffers responses in a 2-entry FIFO toward decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  logic [XLEN-1:0]  pc_f;
  logic [XLEN-1:0]  fifo_pc    [DEPTH];
  logic [XLEN-1:0]  fifo_instr [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [CNT_W-1:0] count;
  logic             inflight;
  logic [XLEN-1:0]  inflight_pc;

  logic             redirect;
  logic [XLEN-1:0]  redirect_addr;
  logic             kill;
  logic             pop;
  logic             push;
  logic [OCC_W-1:0] occupancy;

  // Control: redirect outranks sequential issue; reset masks everything.
  always_comb begin
    redirect      = redirect_valid && !rst;
    redirect_addr = {redirect_pc[XLEN-1:2], 2'b00};
    out_valid     = (count != '0) && !redirect && !rst;
    pop           = out_valid && out_ready;
    // A response landing in a redirect cycle belongs to the abandoned stream.
    kill          = redirect;
    push          = inflight && !kill && !rst;
    occupancy     = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    imem_en       = 1'b0;
    imem_addr     = pc_f;
    if (rst) begin
      imem_en = 1'b0;
    end else if (redirect) begin
      imem_en   = 1'b1;
      imem_addr = redirect_addr;
    end else if (occupancy < OCC_W'(DEPTH)) begin
      imem_en = 1'b1;
    end
  end

  assign out_pc    = fifo_pc[rd_ptr];
  assign out_instr = fifo_instr[rd_ptr];

  // Control state: fetch PC, FIFO pointers/count, in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= imem_en;
      inflight_pc <= imem_addr;
      if (redirect) begin
        pc_f   <= redirect_addr + XLEN'(4);
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= '0;
      end else begin
        if (imem_en) pc_f <= pc_f + XLEN'(4);
        if (push)    wr_ptr <= ~wr_ptr;
        if (pop)     rd_ptr <= ~rd_ptr;
        count <= CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
      end
    end
  end

  // Payload storage needs no reset; valid-ness is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  // Issue throttling must always leave room for the in-flight response.
  always_ff @(posedge clk) begin
    if (!rst && push && !pop) begin
      assert (count < CNT_W'(DEPTH))
        else $error("fetch_stage FIFO overflow");
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a one-cycle-latency memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_2000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Memory returns the inverted address so instr and pc are distinguishable.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a;
  endfunction

  always @(posedge clk) imem_rdata <= imem_en ? mem(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  task automatic chk_issue(input string tag, input logic [31:0] addr);
    chk({tag, "_en"}, 32'(imem_en), 32'd1);
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, mem(pc));
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;

    // Reset state
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);

    // Streaming from reset, out_ready=1
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_issue("s0", 32'h2000);
    chk("s0_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_issue("s1", 32'h2004);
    chk("s1_valid", 32'(out_valid), 32'd0);
    for (int i = 2; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk_issue("s_str", 32'h2000 + 32'(4 * i));
      chk_out("s_str", 32'h2000 + 32'(4 * (i - 2)));
    end

    // Reset pulse, then stall decode for 6 cycles from first out_valid
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk_issue("b0", 32'h2000);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk_issue("b1", 32'h2004);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk_out("b_hold", 32'h2000);
      chk("b_hold_en", 32'(imem_en), 32'd0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("b_rel0", 32'h2000);
    chk_issue("b_rel0", 32'h2008);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("b_rel1", 32'h2004);
    chk_issue("b_rel1", 32'h200C);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("b_rel2", 32'h2008);
    chk_issue("b_rel2", 32'h2010);

    // Stall one cycle to fill the FIFO, then redirect with out_ready=1
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("f_fill", 32'h200C);
    chk("f_fill_en", 32'(imem_en), 32'd0);
    step(1'b0, 1'b1, 32'h0000_3001, 1'b1);
    chk_issue("r0", 32'h3000);
    chk("r0_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("r1_valid", 32'(out_valid), 32'd0);
    chk_issue("r1", 32'h3004);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("r2", 32'h3000);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("r3", 32'h3004);

    // Back-to-back redirects: only the last target survives
    step(1'b0, 1'b1, 32'h0000_4000, 1'b1);
    chk_issue("d0", 32'h4000);
    chk("d0_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 32'h0000_5000, 1'b1);
    chk_issue("d1", 32'h5000);
    chk("d1_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("d2_valid", 32'(out_valid), 32'd0);
    chk_issue("d2", 32'h5004);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("d3", 32'h5000);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("d4", 32'h5004);

    // Reset pulse mid-stream, redirect_valid ignored while in reset
    step(1'b1, 1'b1, 32'h0000_7000, 1'b1);
    chk("x0_en", 32'(imem_en), 32'd0);
    chk("x0_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("x1_valid", 32'(out_valid), 32'd0);
    chk_issue("x1", 32'h2000);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("x2_valid", 32'(out_valid), 32'd0);
    chk_issue("x2", 32'h2004);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("x3", 32'h2000);

    // PC wrap past the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    chk_issue("w0", 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_issue("w1", 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("w2", 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("w3", 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
